riscv_mem_arbiter: RTL and testbench
====================================

// Module: riscv_mem_arbiter
// PURPOSE
// - Shares one single-port synchronous memory between the IF stage (instruction fetch, read-only)
//   and the MEM stage (load/store) of the 5-stage RV32I pipeline.
// - Serialises accesses and returns read data with a one-cycle ack. Drives stall_if/stall_mem into the hazard path.
// - Honours branch flushes by discarding in-flight fetch results.
// PARAMETERS
// - ADDR_W        32  address width (byte address)
// - DATA_W        32  data width
// - MEM_LATENCY   1   cycles from the mem_en pulse to valid mem_rdata; must be >= 1
// - STARVE_LIMIT  4   consecutive data grants with a pending fetch before the fetch is forced (macro only)
// PORTS
// - clk        in   1        single clock, rising edge
// - reset      in   1        synchronous, active-high
// - if_req     in   1        fetch request; held with if_addr until if_ack or if_flush
// - if_addr    in   ADDR_W   fetch address
// - if_flush   in   1        branch taken: discard the granted, un-acked fetch
// - if_ack     out  1        one-cycle pulse; if_rdata valid in the same cycle
// - if_rdata   out  DATA_W   instruction word
// - d_req      in   1        data request; held with addr/we/be/wdata until d_ack
// - d_we       in   1        1 = store, 0 = load
// - d_addr     in   ADDR_W   data address
// - d_be       in   4        store byte enables
// - d_wdata    in   DATA_W   store data
// - d_ack      out  1        one-cycle pulse; load data / store completion
// - d_rdata    out  DATA_W   load data; meaningful only when !d_we
// - stall_if   out  1        if_req & ~if_ack (combinational)
// - stall_mem  out  1        d_req & ~d_ack (combinational)
// - mem_en     out  1        one-cycle access strobe (registered)
// - mem_we     out  1        write strobe, qualified by mem_en
// - mem_addr   out  ADDR_W   registered address
// - mem_be     out  4        registered byte enables (4'hF for fetch)
// - mem_wdata  out  DATA_W   registered write data
// - mem_rdata  in   DATA_W   valid MEM_LATENCY cycles after the mem_en cycle
// BEHAVIOUR
// - Reset values: state IDLE, grant NONE, all mem_* = 0, if_ack = d_ack = 0, counters 0.
// - FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   - IDLE: sample requests and choose the grant. Capture addr/we/be/wdata into the mem_* registers.
//     No request means stay in IDLE.
//   - ISSUE (cycle T): mem_en = 1. Load cnt = MEM_LATENCY-1 and go to WAIT.
//   - WAIT: when cnt == 0, the cycle is T+MEM_LATENCY. Pulse the ack of the grantee with
//     *_rdata = mem_rdata (passthrough), then go to IDLE. Otherwise decrement cnt.
// - Timing: request sampled in cycle 0 gives mem_en in cycle 1 and ack in cycle 1+MEM_LATENCY.
// - Throughput: one access per MEM_LATENCY+2 cycles. The request line in the ack cycle is never re-sampled.
// - Priority: when d_req and if_req are both set in IDLE, data wins (older instruction).
// - Requesters may change addr freely before grant; the arbiter uses only the value captured in IDLE.
// - Flush:
//   - if_flush while the fetch is granted (ISSUE/WAIT, including the ack cycle): suppress if_ack.
//     The memory read still completes and its result is dropped.
//   - if_flush with no fetch granted: no effect.
//   - Data accesses are never flushed.
// - Reset mid-operation: abandons the access, with no ack and next state IDLE.
//   A store whose mem_en already pulsed is not recalled.
// - Widths: no arithmetic on data. cnt is $clog2(MEM_LATENCY+1) bits.
// CONFIGURATION
// - MEM_ARB_STARVE_GUARD_EN defined:
//   - A counter increments on each data grant while if_req is pending and clears on a fetch grant.
//   - When the count reaches STARVE_LIMIT, the next IDLE grant goes to fetch even if d_req is set.
// - Macro undefined: strict data priority; fetch can starve while d_req stays high.
// STRUCTURE
// - Package riscv_mem_pkg:
//   - arb_state_t {IDLE, ISSUE, WAIT}
//   - grant_t {GNT_NONE, GNT_IF, GNT_D}
//   - localparam BE_WORD = 4'hF
// - Sub-module riscv_arb_select: combinational priority select plus the starvation counter register.
//   The FSM and mem_* registers stay in the top module.
// TESTING
// - Fetch, LAT=1:
//   - Stimulus: if_req, addr 0x0, mem_rdata 0x00500093.
//   - Response: mem_en=1 in cycle 1 with mem_addr 0x0 and mem_be 0xF; if_ack in cycle 2 with if_rdata 0x00500093.
// - Conflict, LAT=1:
//   - Stimulus: if_req at 0x10 and a d_req store (0x100, 0xDEADBEEF, be 0xF) in cycle 0.
//   - Response: store issued in cycle 1 with mem_we=1; d_ack in cycle 2; fetch mem_en in cycle 4; if_ack in cycle 5.
//   - stall_if is high in cycles 0-4.
// - Flush:
//   - Stimulus: fetch 0x8 granted and if_flush asserted in the ack cycle.
//   - Response: no if_ack. The next request, 0x20, gets its ack exactly 1+LAT cycles after it is sampled.
// - Latency, MEM_LATENCY=3:
//   - Stimulus: a load from 0x40.
//   - Response: d_ack exactly 3 cycles after the mem_en cycle, with d_rdata equal to mem_rdata in that cycle.
// - Reset mid-WAIT, MEM_LATENCY=3:
//   - Stimulus: reset asserted one cycle after mem_en.
//   - Response: next cycle state IDLE, mem_en 0, no ack in any later cycle for that access.
// - Starvation, STARVE_LIMIT=2, d_req and if_req held high:
//   - Macro defined: grant order D, D, IF, D, D, IF.
//   - Macro undefined: if_ack never asserts within 20 cycles.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter.
package riscv_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} grant_t;
  localparam logic [3:0] BE_WORD = 4'hF;
endpackage

// File: rtl/riscv_arb_select.sv
// Grant selection between fetch and data requests; data wins unless the
// starvation guard (MEM_ARB_STARVE_GUARD_EN) forces a pending fetch through.
module riscv_arb_select
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   sample,
  input  logic   if_req,
  input  logic   d_req,
  output grant_t grant
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic [SC_W-1:0] starve_cnt;
  logic            starved;

  assign starved = GUARD && (starve_cnt >= LIMIT);

  always_comb begin
    grant = GNT_NONE;
    if (sample) begin
      if (if_req && (starved || !d_req)) grant = GNT_IF;
      else if (d_req)                    grant = GNT_D;
    end
  end

  // Counts data grants that overtook a waiting fetch; a fetch grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (GUARD) begin
      if (grant == GNT_IF)
        starve_cnt <= '0;
      else if (grant == GNT_D && if_req)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one synchronous memory port.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_be,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t       state, state_nxt;
  grant_t           grant, sel;
  logic [CNT_W-1:0] cnt;
  logic             flushed;
  logic             done;

  riscv_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk    (clk),
    .reset  (reset),
    .sample (state == IDLE),
    .if_req (if_req),
    .d_req  (d_req),
    .grant  (sel)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel != GNT_NONE) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      cnt       <= '0;
      flushed   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nxt;
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          grant   <= sel;
          flushed <= 1'b0;
          if (sel == GNT_D) begin
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_be    <= d_be;
            mem_wdata <= d_wdata;
          end else if (sel == GNT_IF) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_be    <= BE_WORD;
            mem_wdata <= '0;
          end
        end
        ISSUE: cnt <= CNT_W'(MEM_LATENCY - 1);
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           grant <= GNT_NONE;
        end
        default: ;
      endcase
      // A flush anywhere in the fetch's flight kills its ack; the read itself still completes.
      if (grant == GNT_IF && state != IDLE && if_flush) flushed <= 1'b1;
    end
  end

  assign done      = (state == WAIT) && (cnt == '0) && !reset;
  assign if_ack    = done && (grant == GNT_IF) && !flushed && !if_flush;
  assign d_ack     = done && (grant == GNT_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: a MEM_LATENCY=1 instance (starve limit 2)
// and a MEM_LATENCY=3 instance, with ack scoreboards per requester.
module tb_riscv_mem_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t if_q1[$];
  exp_t d_q1[$];
  exp_t d_q3[$];

  // instance 1: MEM_LATENCY=1, STARVE_LIMIT=2
  logic        reset1, if_req1, if_flush1, if_ack1, d_req1, d_we1, d_ack1;
  logic        stall_if1, stall_mem1, mem_en1, mem_we1;
  logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  d_be1, mem_be1;

  // instance 3: MEM_LATENCY=3
  logic        reset3, if_req3, if_flush3, if_ack3, d_req3, d_we3, d_ack3;
  logic        stall_if3, stall_mem3, mem_en3, mem_we3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  d_be3, mem_be3;

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00500093 : {a[15:0], ~a[15:0]};
  endfunction

  function automatic exp_t mk(input int c, input logic [31:0] d, input bit chk);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    e.chk  = chk;
    return e;
  endfunction

  assign mem_rdata1 = model(mem_addr1);
  assign mem_rdata3 = model(mem_addr3) ^ 32'(cyc);

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)) u1 (
    .clk(clk), .reset(reset1),
    .if_req(if_req1), .if_addr(if_addr1), .if_flush(if_flush1), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_be(d_be1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_be(mem_be1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u3 (
    .clk(clk), .reset(reset3),
    .if_req(if_req3), .if_addr(if_addr3), .if_flush(if_flush3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_be(d_be3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3), .stall_if(stall_if3), .stall_mem(stall_mem3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_be(mem_be3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ack scoreboards: every ack must match the head entry in cycle and data.
  always @(negedge clk) begin
    exp_t e;
    if (if_ack1) begin
      check("if1_ack_expected", 32'(if_q1.size() != 0), 32'd1);
      if (if_q1.size() != 0) begin
        e = if_q1.pop_front();
        check("if1_ack_cycle", cyc, e.cyc);
        if (e.chk) check("if1_rdata", if_rdata1, e.data);
      end
    end
    if (d_ack1) begin
      check("d1_ack_expected", 32'(d_q1.size() != 0), 32'd1);
      if (d_q1.size() != 0) begin
        e = d_q1.pop_front();
        check("d1_ack_cycle", cyc, e.cyc);
        if (e.chk) check("d1_rdata", d_rdata1, e.data);
      end
    end
    if (d_ack3) begin
      check("d3_ack_expected", 32'(d_q3.size() != 0), 32'd1);
      if (d_q3.size() != 0) begin
        e = d_q3.pop_front();
        check("d3_ack_cycle", cyc, e.cyc);
        if (e.chk) check("d3_rdata", d_rdata3, e.data);
      end
    end
    if (if_ack3) check("if3_ack_unexpected", {31'b0, if_ack3}, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset1 = 1'b1; if_req1 = 0; if_addr1 = '0; if_flush1 = 0;
    d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_be1 = '0; d_wdata1 = '0;
    reset3 = 1'b1; if_req3 = 0; if_addr3 = '0; if_flush3 = 0;
    d_req3 = 0; d_we3 = 0; d_addr3 = '0; d_be3 = '0; d_wdata3 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en1", mem_en1, 0);
    check("rst_mem_addr1", mem_addr1, 0);
    check("rst_mem_be_we1", {mem_be1, mem_we1}, 0);
    check("rst_acks1", {if_ack1, d_ack1}, 0);
    check("rst_mem_en3", mem_en3, 0);
    check("rst_mem_wdata3", mem_wdata3, 0);
    check("rst_stall_if3", stall_if3, 0);
    step();
    reset1 = 1'b0; reset3 = 1'b0;
    step();

    // Single fetch, latency 1
    c = cyc;
    if_req1 = 1; if_addr1 = 32'h0;
    if_q1.push_back(mk(c + 2, 32'h00500093, 1'b1));
    @(negedge clk);
    check("fetch_stall_if_c0", stall_if1, 1);
    step();
    @(negedge clk);
    check("fetch_mem_en", mem_en1, 1);
    check("fetch_mem_addr", mem_addr1, 32'h0);
    check("fetch_mem_be", mem_be1, 4'hF);
    check("fetch_mem_we", mem_we1, 0);
    step();
    @(negedge clk);
    check("fetch_stall_if_ack", stall_if1, 0);
    step();
    if_req1 = 0;

    // Fetch and store together: data goes first
    c = cyc;
    if_addr1 = 32'h10;
    d_we1 = 1; d_addr1 = 32'h100; d_wdata1 = 32'hDEADBEEF; d_be1 = 4'hF;
    d_q1.push_back(mk(c + 2, 32'h0, 1'b0));
    if_q1.push_back(mk(c + 5, model(32'h10), 1'b1));
    for (int k = 0; k <= 5; k++) begin
      if_req1 = 1;
      d_req1  = (k <= 2);
      @(negedge clk);
      check("conf_stall_if", stall_if1, 32'(k <= 4));
      check("conf_stall_mem", stall_mem1, 32'(k <= 1));
      if (k == 1) begin
        check("conf_st_mem_en", mem_en1, 1);
        check("conf_st_mem_we", mem_we1, 1);
        check("conf_st_mem_addr", mem_addr1, 32'h100);
        check("conf_st_mem_wdata", mem_wdata1, 32'hDEADBEEF);
        check("conf_st_mem_be", mem_be1, 4'hF);
      end
      if (k == 3) check("conf_gap_mem_en", mem_en1, 0);
      if (k == 4) begin
        check("conf_if_mem_en", mem_en1, 1);
        check("conf_if_mem_we", mem_we1, 0);
        check("conf_if_mem_addr", mem_addr1, 32'h10);
      end
      step();
    end
    if_req1 = 0; d_req1 = 0; d_we1 = 0;

    // Flush in the ack cycle, then a fresh fetch
    if_req1 = 1; if_addr1 = 32'h8;
    step();
    step();
    if_flush1 = 1;
    @(negedge clk);
    check("flush_no_ack", if_ack1, 0);
    check("flush_mem_addr", mem_addr1, 32'h8);
    step();
    if_flush1 = 0;
    c = cyc;
    if_addr1 = 32'h20;
    if_q1.push_back(mk(c + 2, model(32'h20), 1'b1));
    step();
    step();
    step();
    if_req1 = 0;

    // Starvation: both requests held high
    c = cyc;
    if_req1 = 1; if_addr1 = 32'h300;
    d_req1 = 1; d_we1 = 0; d_addr1 = 32'h200;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 6; k++) begin
      if (k % 3 == 2) if_q1.push_back(mk(c + 2 + 3 * k, model(32'h300), 1'b1));
      else            d_q1.push_back(mk(c + 2 + 3 * k, model(32'h200), 1'b1));
    end
    repeat (18) step();
`else
    for (int k = 0; k < 7; k++) d_q1.push_back(mk(c + 2 + 3 * k, model(32'h200), 1'b1));
    repeat (21) step();
`endif
    if_req1 = 0; d_req1 = 0;

    // Load with latency 3; a flush during a data access is ignored
    c = cyc;
    d_req3 = 1; d_we3 = 0; d_addr3 = 32'h40; d_be3 = 4'hF;
    d_q3.push_back(mk(c + 4, model(32'h40) ^ 32'(c + 4), 1'b1));
    step();
    @(negedge clk);
    check("lat_mem_en", mem_en3, 1);
    check("lat_mem_addr", mem_addr3, 32'h40);
    check("lat_mem_we_be", {mem_we3, mem_be3}, 5'h0F);
    step();
    @(negedge clk);
    check("lat_mem_en_pulse", mem_en3, 0);
    step();
    step();
    if_flush3 = 1;
    @(negedge clk);
    check("lat_stall_mem_ack", stall_mem3, 0);
    check("lat_if_rdata_pass", if_rdata3, model(32'h40) ^ 32'(c + 4));
    step();
    if_flush3 = 0; d_req3 = 0;

    // Reset one cycle after mem_en abandons the load
    d_req3 = 1; d_addr3 = 32'h44;
    step();
    @(negedge clk);
    check("rstw_mem_en", mem_en3, 1);
    step();
    reset3 = 1; d_req3 = 0;
    @(negedge clk);
    check("rstw_no_ack_in_reset", d_ack3, 0);
    step();
    reset3 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rstw_mem_en_after", mem_en3, 0);
      check("rstw_no_ack_after", d_ack3, 0);
      step();
    end

    // Arbiter still serves a load after the abandoned one
    c = cyc;
    d_req3 = 1; d_addr3 = 32'h48;
    d_q3.push_back(mk(c + 4, model(32'h48) ^ 32'(c + 4), 1'b1));
    repeat (5) step();
    d_req3 = 0;
    step();
    step();

    check("if1_queue_drained", if_q1.size(), 0);
    check("d1_queue_drained", d_q1.size(), 0);
    check("d3_queue_drained", d_q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
